regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Shares the register file's single 64-bit read port (32x64 -> 64 mux, 5-bit select) among
//  NUM_REQ requesters. Round-robin grant, valid/ready on both request and response, registered
//  response data. Sits between the register file and its clients (decode, debug, test loader).
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  reset_n      in   1            synchronous, active-low reset
//  req_valid    in   NUM_REQ      per-requester read request
//  req_addr     in   NUM_REQ x 5  per-requester register number, packed [NUM_REQ-1:0][4:0]
//  req_ready    out  NUM_REQ      one-hot grant; request accepted when valid & ready
//  rf_read_reg  out  5            select to register-file read mux
//  rf_read_data in   64           data from register-file read mux, same cycle
//  wr_en        in   1            register-file write enable (used only with bypass)
//  wr_reg       in   5            register-file write address
//  wr_data      in   64           register-file write data
//  resp_valid   out  NUM_REQ      one-hot: response for that requester is on resp_data
//  resp_data    out  64           registered read data
//  resp_ready   in   NUM_REQ      requester accepts response
//  busy         out  1            response pending (state == RESP)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, resp_valid=0, resp_data=0, rr_ptr=0, owner=0.
//    Combinational outputs during reset: req_ready=0, rf_read_reg=5'd31.
//    Reset mid-RESP drops the pending response silently.
//  - FSM: IDLE, RESP.
//    grant_ok = (state==IDLE) | (state==RESP & resp_ready[owner]).
//  - Grant: when grant_ok and |req_valid, g = first valid index at or after rr_ptr (wrapping
//    NUM_REQ-1 -> 0). req_ready = onehot(g), same cycle; rf_read_reg = req_addr[g].
//  - Accept edge: resp_data <= rf_read_data, resp_valid <= onehot(g), owner <= g,
//    rr_ptr <= (g+1) mod NUM_REQ, state <= RESP. Latency: response valid 1 cycle after accept.
//  - RESP: resp_valid and resp_data hold until resp_ready[owner]. resp_ready on non-owner bits
//    is ignored. If accepted and no new grant this cycle: resp_valid <= 0, state <= IDLE.
//    Accept and new grant in the same cycle: back-to-back, 1 read per cycle sustained.
//  - No grant: req_ready=0, rf_read_reg=5'd31, rr_ptr unchanged.
//  - Requester may drop req_valid before being granted; no commitment is held.
//  - All requesters valid: each is granted exactly once per NUM_REQ grants.
//  - Single requester: granted every eligible cycle.
//  - Address 31 is passed through unchanged; zero-register semantics belong to the register file.
// CONFIGURATION
//  RF_ARB_WR_BYPASS_EN defined:
//    if wr_en & (wr_reg == req_addr[g]) & (wr_reg != 31) in the grant cycle,
//    resp_data captures wr_data instead of rf_read_data (write-to-read forwarding).
//  Undefined: wr_en, wr_reg and wr_data are ignored; resp_data always equals rf_read_data.
// STRUCTURE
//  - Package regfile_arb_pkg:
//    REG_ADDR_W=5, DATA_W=64, NUM_REGS=32, ZERO_REG=5'd31,
//    typedef enum logic {IDLE, RESP} arb_state_t, typedef logic [63:0] reg_data_t.
//  - Sub-module rr_arbiter (NUM_REQ): req vector and rr_ptr -> one-hot grant and index;
//    purely combinational.
//  - Top holds the FSM, rr_ptr, owner and response registers.
// TESTING
//  1 Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0,
//    rf_read_reg=31.
//  2 Single read: req0 addr=5, mux returns 64'hDEAD_BEEF -> req_ready=0001 same cycle;
//    next cycle resp_valid=0001, resp_data=DEAD_BEEF, held until resp_ready[0].
//  3 Fairness: all 4 valid, resp_ready=1111 -> grants 0,1,2,3,0 on consecutive cycles.
//    One response per cycle, no bubbles.
//  4 Backpressure: resp_ready[1]=0 for 3 cycles while req2 valid -> resp held constant,
//    req_ready=0, busy=1. On release, req2 is granted in the same cycle.
//  5 Bypass (macro on): grant addr=7 with wr_en=1, wr_reg=7, wr_data=64'h1234 -> resp_data=1234.
//    Same stimulus with macro off -> resp_data=rf_read_data. wr_reg=31 never bypasses.
//  6 Reset mid-RESP: reset_n=0 while resp_valid=0100 -> next cycle resp_valid=0, state IDLE,
//    rr_ptr=0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: returns the first asserted
// request at or after ptr_i, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back to ptr_i so the last hit kept
    // is the closest one to the pointer.
    always_comb begin
        sum         = '0;
        idx         = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        grant_o     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (req_i[idx]) begin
                grant_idx_o = idx;
                grant_any_o = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = grant_any_o && (grant_idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's single read port among NUM_REQ requesters.
// Round-robin grant, valid/ready request and response, registered data.
// Optional write-to-read forwarding: define RF_ARB_WR_BYPASS_EN.
//
// Handshake: a request transfers on the edge where req_valid[i] & req_ready[i];
// a response transfers on the edge where resp_valid[i] & resp_ready[i]. Both
// ready signals are combinational; resp_valid/resp_data hold until accepted.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [REG_ADDR_W-1:0]              rf_read_reg,
    input  logic [DATA_W-1:0]                  rf_read_data,
    input  logic                               wr_en,
    input  logic [REG_ADDR_W-1:0]              wr_reg,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [DATA_W-1:0]                  resp_data,
    input  logic [NUM_REQ-1:0]                 resp_ready,
    output logic                               busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               owner_ack;
    logic               grant_ok;
    logic               do_grant;
    logic [DATA_W-1:0]  capture_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // A new read may start when idle, or when the pending response is
    // being taken this very cycle (back-to-back reads).
    assign owner_ack = (state_q == RESP) && resp_ready[owner_q];
    assign grant_ok  = (state_q == IDLE) || owner_ack;
    assign do_grant  = reset_n && grant_ok && grant_any;

    assign req_ready   = do_grant ? grant_oh : '0;
    assign rf_read_reg = do_grant ? req_addr[grant_idx] : ZERO_REG;

`ifdef RF_ARB_WR_BYPASS_EN
    // Forward a same-cycle write so the reader never sees stale data.
    assign capture_data = (wr_en && (wr_reg == rf_read_reg) && (wr_reg != ZERO_REG))
                        ? wr_data : rf_read_data;
`else
    logic unused_wr;
    assign unused_wr    = ^{wr_en, wr_reg, wr_data};
    assign capture_data = rf_read_data;
`endif

    // Next-state: retire the accepted response, then let a new grant override.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        if (owner_ack) begin
            resp_valid_d = '0;
            state_d      = IDLE;
        end
        if (do_grant) begin
            resp_valid_d = grant_oh;
            resp_data_d  = capture_data;
            owner_d      = grant_idx;
            rr_ptr_d     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            state_d      = RESP;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q == RESP);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter (NUM_REQ = 4). The bench acts
// as the register file and keeps a transaction-level model of the arbiter.
module tb_regfile_read_arbiter;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0][4:0]   req_addr;
    logic [N-1:0]        req_ready;
    logic [4:0]          rf_read_reg;
    logic [63:0]         rf_read_data;
    logic                wr_en;
    logic [4:0]          wr_reg;
    logic [63:0]         wr_data;
    logic [N-1:0]        resp_valid;
    logic [63:0]         resp_data;
    logic [N-1:0]        resp_ready;
    logic                busy;

    logic [63:0] regs [32];

    int checks = 0;
    int errors = 0;

    regfile_read_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .wr_en        (wr_en),
        .wr_reg       (wr_reg),
        .wr_data      (wr_data),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy)
    );

    // Clock and register-file read mux
    always #5 clk = ~clk;
    assign rf_read_data = regs[rf_read_reg];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: at most one outstanding response, a rotating
    // priority pointer, and the data the register file held at grant time.
    bit          m_known = 1'b0;
    bit          m_pend  = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    logic [63:0] m_data  = '0;
    bit          n_pend  = 1'b0;
    int          n_owner = 0;
    int          n_ptr   = 0;
    logic [63:0] n_data  = '0;
    int          g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [4:0]   exp_reg;

    // Compare process: check DUT against the model, then work out the model's next state
    always @(negedge clk) begin
        g = -1;
        if (reset_n && (!m_pend || resp_ready[m_owner])) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = '0;
        exp_rv  = '0;
        exp_reg = 5'd31;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_reg    = req_addr[g];
        end
        if (m_pend) exp_rv[m_owner] = 1'b1;
        if (m_known) begin
            check("m_req_ready", req_ready, exp_rdy);
            check("m_rf_read_reg", rf_read_reg, exp_reg);
            check("m_resp_valid", resp_valid, exp_rv);
            check("m_busy", busy, m_pend);
            if (m_pend) check("m_resp_data", resp_data, m_data);
        end
        n_pend = m_pend; n_owner = m_owner; n_ptr = m_ptr; n_data = m_data;
        if (!reset_n) begin
            n_pend = 1'b0; n_owner = 0; n_ptr = 0; n_data = '0;
        end else if (g >= 0) begin
            n_pend  = 1'b1;
            n_owner = g;
            n_ptr   = (g + 1) % N;
            n_data  = regs[req_addr[g]];
`ifdef RF_ARB_WR_BYPASS_EN
            if (wr_en && wr_reg == req_addr[g] && wr_reg != 5'd31) n_data = wr_data;
`endif
        end else if (m_pend && resp_ready[m_owner]) begin
            n_pend = 1'b0;
        end
    end

    // Model commit and register-file write port
    always @(posedge clk) begin
        if (!reset_n) m_known <= 1'b1;
        m_pend  <= n_pend;
        m_owner <= n_owner;
        m_ptr   <= n_ptr;
        m_data  <= n_data;
        if (wr_en) regs[wr_reg] <= wr_data;
    end

    logic [63:0] old7, old31;

    // Directed scenarios followed by random traffic
    initial begin
        reset_n    = 1'b0;
        req_valid  = '1;
        resp_ready = '0;
        wr_en      = 1'b0;
        wr_reg     = '0;
        wr_data    = '0;
        for (int i = 0; i < N; i++) req_addr[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};

        // Reset with every requester asking
        step();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rf_read_reg", rf_read_reg, 31);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);

        // Single read from requester 0
        step();
        reset_n = 1'b1; req_valid = 4'b0001; req_addr[0] = 5'd5; regs[5] = 64'hDEAD_BEEF;
        @(negedge clk);
        check("single_req_ready", req_ready, 4'b0001);
        check("single_rf_read_reg", rf_read_reg, 5);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_resp_valid", resp_valid, 4'b0001);
        check("single_resp_data", resp_data, 64'hDEAD_BEEF);
        step();
        @(negedge clk);
        check("single_hold_valid", resp_valid, 4'b0001);
        check("single_hold_data", resp_data, 64'hDEAD_BEEF);
        step();
        resp_ready = 4'b0001;
        step();
        resp_ready = '0;
        @(negedge clk);
        check("single_done_valid", resp_valid, 0);
        check("single_done_busy", busy, 0);

        // Fairness from a fresh pointer, no bubbles
        step(); reset_n = 1'b0;
        step(); reset_n = 1'b1; req_valid = '1; resp_ready = '1;
        for (int i = 0; i < N; i++) req_addr[i] = 5'(10 + i);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fair_grant", req_ready, 64'(1) << (k % 4));
            if (k > 0) begin
                check("fair_resp_valid", resp_valid, 64'(1) << ((k - 1) % 4));
                check("fair_resp_data", resp_data, regs[10 + (k - 1) % 4]);
            end
            if (k < 4) step();
        end

        // Backpressure on requester 1 while requester 2 waits
        step(); req_valid = 4'b0010;
        @(negedge clk);
        check("bp_grant1", req_ready, 4'b0010);
        step(); req_valid = 4'b0100; resp_ready = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", resp_valid, 4'b0010);
            check("bp_hold_data", resp_data, regs[11]);
            check("bp_req_ready", req_ready, 0);
            check("bp_busy", busy, 1);
            step();
        end
        resp_ready = 4'b0010;
        @(negedge clk);
        check("bp_release_grant", req_ready, 4'b0100);
        step(); req_valid = '0; resp_ready = '0;
        @(negedge clk);
        check("bp_req2_valid", resp_valid, 4'b0100);
        check("bp_req2_data", resp_data, regs[12]);

        // Reset while requester 2's response is pending
        step(); reset_n = 1'b0; req_valid = '1;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_rf_read_reg", rf_read_reg, 31);
        step(); reset_n = 1'b1;
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ptr0_grant", req_ready, 4'b0001);

        // Write during grant: forwarded only with the bypass build, never for reg 31
        step(); req_valid = 4'b0001; req_addr[0] = 5'd7; resp_ready = '1;
        wr_en = 1'b1; wr_reg = 5'd7; wr_data = 64'h1234; old7 = regs[7];
        step(); req_valid = '0; wr_en = 1'b0;
        @(negedge clk);
`ifdef RF_ARB_WR_BYPASS_EN
        check("bypass_data", resp_data, 64'h1234);
`else
        check("nobypass_data", resp_data, old7);
`endif
        step(); req_valid = 4'b0001; req_addr[0] = 5'd31;
        wr_en = 1'b1; wr_reg = 5'd31; wr_data = 64'h5555; old31 = regs[31];
        step(); req_valid = '0; wr_en = 1'b0;
        @(negedge clk);
        check("zero_reg_no_bypass", resp_data, old31);

        // Random traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            step();
            reset_n    = ($urandom_range(0, 149) != 0);
            req_valid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) req_addr[i] = 5'($urandom_range(0, 31));
            resp_ready = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) resp_ready = '1;
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_reg     = ($urandom_range(0, 1) == 1) ? req_addr[$urandom_range(0, N - 1)]
                                                     : 5'($urandom_range(0, 31));
            wr_data    = {$urandom, $urandom};
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
